// File: rtl/fft_pkg.sv
// Shared definitions for the iterative radix-2 DIT FFT sequencer:
// FSM encoding, default sizes and the butterfly address rule.
package fft_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } fft_state_t;

    localparam int FFT_AWL    = 11;
    localparam int FFT_BF_LAT = 4;
    localparam int FFT_SWL    = 4;

    // Stage s pairs points h = 2^s apart; j's low s bits pick the offset in a group.
    function automatic int fftAddrA(input int s, input int j);
        return ((j >> s) << (s + 1)) | (j & ((1 << s) - 1));
    endfunction

    function automatic int fftAddrB(input int s, input int j);
        return fftAddrA(s, j) + (1 << s);
    endfunction

    function automatic int fftTwAddr(input int awl, input int s, input int j);
        return (j & ((1 << s) - 1)) << (awl - 1 - s);
    endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Delay line carrying the butterfly write-back valid flag and A/B addresses
// for DEPTH enabled cycles, so writes line up with the butterfly pipeline.
module fft_wb_delay #(
    parameter int AW    = 11,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          i_valid,
    input  logic [AW-1:0] i_a_addr,
    input  logic [AW-1:0] i_b_addr,
    output logic          o_valid,
    output logic [AW-1:0] o_a_addr,
    output logic [AW-1:0] o_b_addr
);

    logic          r_valid [DEPTH];
    logic [AW-1:0] r_a     [DEPTH];
    logic [AW-1:0] r_b     [DEPTH];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_a[i]     <= '0;
                r_b[i]     <= '0;
            end
        end else if (EN) begin
            r_valid[0] <= i_valid;
            r_a[0]     <= i_a_addr;
            r_b[0]     <= i_b_addr;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_a[i]     <= r_a[i-1];
                r_b[i]     <= r_b[i-1];
            end
        end
    end

    assign o_valid  = r_valid[DEPTH-1];
    assign o_a_addr = r_a[DEPTH-1];
    assign o_b_addr = r_b[DEPTH-1];

endmodule

// File: rtl/fft_iter_ctrl.sv
// Sequencer for the in-place iterative radix-2 DIT FFT: walks every stage and
// butterfly, drives read/twiddle addresses and the delayed write-back addresses.
module fft_iter_ctrl
    import fft_pkg::*;
#(
    parameter int AWL    = FFT_AWL,
    parameter int BF_LAT = FFT_BF_LAT,
    parameter int SWL    = FFT_SWL
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic           START,
    output logic           o_RD_EN,
    output logic [AWL-1:0] o_A_RADDR,
    output logic [AWL-1:0] o_B_RADDR,
    output logic [AWL-2:0] o_TW_ADDR,
    output logic           o_WR_EN,
    output logic [AWL-1:0] o_A_WADDR,
    output logic [AWL-1:0] o_B_WADDR,
    output logic [SWL-1:0] o_STAGE,
    output logic           o_RAM_BLOCK,
    output logic           o_DONE
);

    localparam int CW  = $clog2(BF_LAT + 1);
    localparam int TWW = AWL - 1;
    localparam logic [AWL-2:0] J_LAST     = '1;
    localparam logic [SWL-1:0] STAGE_LAST = SWL'(AWL - 1);
    localparam logic [CW-1:0]  DRAIN_LAST = CW'(BF_LAT - 1);

    fft_state_t     r_state, w_next_state;
    logic [SWL-1:0] r_stage, w_next_stage;
    logic [AWL-2:0] r_j,     w_next_j;
    logic [CW-1:0]  r_drain, w_next_drain;

    logic           w_rd_en;
    logic [AWL-1:0] w_a_raddr;
    logic [AWL-1:0] w_b_raddr;
    logic [AWL-2:0] w_tw_addr;
    logic           w_block;
    logic           w_done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_j     <= '0;
            r_drain <= '0;
        end else if (EN) begin
            r_state <= w_next_state;
            r_stage <= w_next_stage;
            r_j     <= w_next_j;
            r_drain <= w_next_drain;
        end
    end

    // DRAIN waits out the butterfly pipeline before the next stage may read.
    always_comb begin
        w_next_state = r_state;
        w_next_stage = r_stage;
        w_next_j     = r_j;
        w_next_drain = r_drain;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next_state = S_RUN;
                    w_next_stage = '0;
                    w_next_j     = '0;
                end
            end
            S_RUN: begin
                if (r_j == J_LAST) begin
                    w_next_state = S_DRAIN;
                    w_next_drain = '0;
                end else begin
                    w_next_j = r_j + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    if (r_stage == STAGE_LAST) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_RUN;
                        w_next_stage = r_stage + 1'b1;
                        w_next_j     = '0;
                    end
                end else begin
                    w_next_drain = r_drain + 1'b1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in step.
    always_comb begin
        w_rd_en   = (w_next_state == S_RUN);
        w_a_raddr = '0;
        w_b_raddr = '0;
        w_tw_addr = '0;
        if (w_rd_en) begin
            w_a_raddr = AWL'(fftAddrA(int'(w_next_stage), int'(w_next_j)));
            w_b_raddr = AWL'(fftAddrB(int'(w_next_stage), int'(w_next_j)));
            w_tw_addr = TWW'(fftTwAddr(AWL, int'(w_next_stage), int'(w_next_j)));
        end
        w_block = (w_next_state == S_RUN) || (w_next_state == S_DRAIN);
        w_done  = (w_next_state == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            o_RD_EN     <= 1'b0;
            o_A_RADDR   <= '0;
            o_B_RADDR   <= '0;
            o_TW_ADDR   <= '0;
            o_RAM_BLOCK <= 1'b0;
            o_DONE      <= 1'b0;
        end else if (EN) begin
            o_RD_EN     <= w_rd_en;
            o_A_RADDR   <= w_a_raddr;
            o_B_RADDR   <= w_b_raddr;
            o_TW_ADDR   <= w_tw_addr;
            o_RAM_BLOCK <= w_block;
            o_DONE      <= w_done;
        end
    end

    assign o_STAGE = r_stage;

    fft_wb_delay #(
        .AW    (AWL),
        .DEPTH (BF_LAT)
    ) u_wb_delay (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .i_valid  (o_RD_EN),
        .i_a_addr (o_A_RADDR),
        .i_b_addr (o_B_RADDR),
        .o_valid  (o_WR_EN),
        .o_a_addr (o_A_WADDR),
        .o_b_addr (o_B_WADDR)
    );

endmodule
